piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_if.sv | 26 ++
 rtl/piso_serializer.sv | 104 ++++++++++
 tb/tb_piso_serializer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-word input stream and serial-bit output stream of the serializer.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface piso_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int LEN_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] din;
    logic [LEN_W-1:0]      din_len;
    logic                  din_valid;
    logic                  din_ready;
    logic                  dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  dout_last;

    modport slave (
        input  din, din_len, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_last
    );

    modport master (
        output din, din_len, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word skid register.
// Variable word length, LSB- or MSB-first order, and back-to-back words with no bubble.
module piso_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    piso_serializer_if.slave    s,
    output logic                busy
);
    localparam int LEN_W = $clog2(DATA_WIDTH + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_WIDTH);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] pend_data_q;
    logic [LEN_W-1:0]      pend_len_q;
    logic                  pend_full_q;

    logic [DATA_WIDTH-1:0] in_shreg;
    logic [LEN_W-1:0]      in_len;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  accept;
    logic                  xfer;
    logic                  last_xfer;

    // Incoming words are normalised so the next bit to send always sits at the output end.
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        in_len = s.din_len;
        if (s.din_len == '0 || s.din_len > FULL_LEN) in_len = FULL_LEN;
        if (MSB_FIRST) in_shreg = s.din << (FULL_LEN - in_len);
        else           in_shreg = s.din & ({DATA_WIDTH{1'b1}} >> (FULL_LEN - in_len));
    end

    assign shifted = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, shreg_q[DATA_WIDTH-1:1]};

    assign s.din_ready  = ~pend_full_q & resetn;
    assign s.dout_valid = (state_q == SHIFT);
    assign s.dout       = s.dout_valid & (MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0]);
    assign s.dout_last  = s.dout_valid & (cnt_q == LEN_W'(1));
    assign busy         = s.dout_valid | pend_full_q;

    assign accept    = s.din_valid & s.din_ready;
    assign xfer      = s.dout_valid & s.dout_ready;
    assign last_xfer = xfer & (cnt_q == LEN_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            // NOTE: data registers are cleared too, so a stale word can never reappear after release.
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            pend_data_q <= '0;
            pend_len_q  <= '0;
            pend_full_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= in_shreg;
                        cnt_q   <= in_len;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_xfer) begin
                        // Refill from pending first, then from the input, so words run back to back.
                        if (pend_full_q) begin
                            shreg_q     <= pend_data_q;
                            cnt_q       <= pend_len_q;
                            pend_full_q <= 1'b0;
                        end else if (accept) begin
                            shreg_q <= in_shreg;
                            cnt_q   <= in_len;
                        end else begin
                            shreg_q <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            shreg_q <= shifted;
                            cnt_q   <= cnt_q - LEN_W'(1);
                        end
                        if (accept) begin
                            pend_data_q <= in_shreg;
                            pend_len_q  <= in_len;
                            pend_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: LSB-first and MSB-first serializers driven with identical stimulus,
// each checked bit by bit against a word-level reference model.
module tb_piso_serializer;
    localparam int DW = 8;
    localparam int LW = $clog2(DW + 1);

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] din = '0;
    logic [LW-1:0] din_len = '0;
    logic          din_valid = 1'b0;
    logic          dout_ready = 1'b0;
    logic          busy_l, busy_m;
    int            rdy_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random

    int tests = 0;
    int fails = 0;
    int n_xfer = 0;
    int vcount = 0;
    int rises = 0;
    exp_t q_l[$];
    exp_t q_m[$];

    piso_serializer_if #(.DATA_WIDTH(DW)) if_l ();
    piso_serializer_if #(.DATA_WIDTH(DW)) if_m ();

    assign if_l.din = din;        assign if_m.din = din;
    assign if_l.din_len = din_len; assign if_m.din_len = din_len;
    assign if_l.din_valid = din_valid; assign if_m.din_valid = din_valid;
    assign if_l.dout_ready = dout_ready; assign if_m.dout_ready = dout_ready;

    piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .resetn(resetn), .flush(flush), .s(if_l), .busy(busy_l)
    );
    piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .resetn(resetn), .flush(flush), .s(if_m), .busy(busy_m)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes its list of bits in transmit order.
    task automatic model_push(input logic [DW-1:0] d, input int len);
        int   n;
        exp_t e;
        n = (len == 0 || len > DW) ? DW : len;
        for (int i = 0; i < n; i++) begin
            e.last = (i == n - 1);
            e.b = d[i];
            q_l.push_back(e);
            e.b = d[n-1-i];
            q_m.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            2:       dout_ready = ~dout_ready;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stimulus side of the scoreboard: an accepted word pushes its expected bits.
    always @(negedge clk) begin
        if (!resetn || flush) begin
            q_l.delete();
            q_m.delete();
        end else if (din_valid && if_l.din_ready) begin
            model_push(din, int'(din_len));
        end
    end

    // Monitor: pops and compares on every transfer, checks holds on stalls and zeros when idle.
    logic       stall_l = 1'b0, stall_m = 1'b0, prev_v = 1'b0;
    logic [1:0] hold_l = '0, hold_m = '0;
    always @(negedge clk) begin
        exp_t e;
        if (resetn && !flush) begin
            if (if_l.dout_valid) begin
                vcount++;
                if (!prev_v) rises++;
            end
            prev_v = if_l.dout_valid;
            if (stall_l) check("hold_lsb", {if_l.dout_valid, if_l.dout, if_l.dout_last}, {1'b1, hold_l});
            if (stall_m) check("hold_msb", {if_m.dout_valid, if_m.dout, if_m.dout_last}, {1'b1, hold_m});
            if (!if_l.dout_valid) check("idle_zero_lsb", {if_l.dout, if_l.dout_last}, 0);
            if (!if_m.dout_valid) check("idle_zero_msb", {if_m.dout, if_m.dout_last}, 0);
            if (if_l.dout_valid && dout_ready) begin
                n_xfer++;
                if (q_l.size() == 0) check("unexpected_bit_lsb", 1, 0);
                else begin
                    e = q_l.pop_front();
                    check("bit_lsb", {if_l.dout, if_l.dout_last}, {e.b, e.last});
                end
            end
            if (if_m.dout_valid && dout_ready) begin
                if (q_m.size() == 0) check("unexpected_bit_msb", 1, 0);
                else begin
                    e = q_m.pop_front();
                    check("bit_msb", {if_m.dout, if_m.dout_last}, {e.b, e.last});
                end
            end
            stall_l = if_l.dout_valid && !dout_ready;
            stall_m = if_m.dout_valid && !dout_ready;
            hold_l  = {if_l.dout, if_l.dout_last};
            hold_m  = {if_m.dout, if_m.dout_last};
        end else begin
            stall_l = 1'b0;
            stall_m = 1'b0;
            prev_v  = 1'b0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [LW-1:0] l);
        din = d;
        din_len = l;
        din_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if_l.din_ready) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 1, 0);
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy_l && !busy_m && !if_l.dout_valid && !if_m.dout_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        check(name, {if_l.dout_valid, if_m.dout_valid, busy_l, busy_m}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int v0;
        int r0;

        // Reset behaviour
        cycles(3);
        @(negedge clk);
        check("reset_outputs", {if_l.dout_valid, if_l.dout, if_l.dout_last, busy_l, if_l.din_ready}, 0);
        check("reset_outputs_msb", {if_m.dout_valid, if_m.dout, if_m.dout_last, busy_m, if_m.din_ready}, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("release_din_ready", {if_l.din_ready, if_m.din_ready}, 2'b11);
        @(posedge clk);
        #1;

        // 0xA5, length 0 treated as full width, first bit one cycle after accept
        n0 = n_xfer;
        send(8'hA5, 4'd0);
        @(negedge clk);
        check("first_bit_latency", if_l.dout_valid, 1);
        @(posedge clk);
        #1;
        wait_idle();
        check("a5_bit_count", n_xfer - n0, 8);
        check_quiet("a5_back_to_idle");

        // 0x0D, length 4
        n0 = n_xfer;
        send(8'h0D, 4'd4);
        wait_idle();
        check("len4_bit_count", n_xfer - n0, 4);

        // Back-to-back words, skid register full
        n0 = n_xfer; v0 = vcount; r0 = rises;
        send(8'hFF, 4'd8);
        send(8'h00, 4'd8);
        @(negedge clk);
        check("pending_full_din_ready", {if_l.din_ready, busy_l}, 2'b01);
        @(posedge clk);
        #1;
        wait_idle();
        check("b2b_valid_cycles", vcount - v0, 16);
        check("b2b_no_gap", rises - r0, 1);
        check("b2b_bit_count", n_xfer - n0, 16);

        // Stalls with dout_ready toggling
        rdy_mode = 2;
        n0 = n_xfer;
        send(8'h81, 4'd8);
        wait_idle();
        check("stall_bit_count", n_xfer - n0, 8);
        rdy_mode = 1;
        cycles(2);

        // Flush at bit 3 with a pending word
        n0 = n_xfer;
        send(8'hF0, 4'd8);
        send(8'h3C, 4'd8);
        for (int i = 0; i < 50 && (n_xfer - n0) < 3; i++) cycles(1);
        check("flush_at_bit3", n_xfer - n0, 3);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        @(negedge clk);
        check("flush_outputs", {if_l.dout_valid, busy_l, if_m.dout_valid, busy_m, if_l.din_ready}, 5'b00001);
        @(posedge clk);
        #1;
        n0 = n_xfer;
        cycles(10);
        check("flush_no_more_bits", n_xfer - n0, 0);

        // Reset at bit 3 with a pending word
        n0 = n_xfer;
        send(8'hF0, 4'd8);
        send(8'hC3, 4'd8);
        for (int i = 0; i < 50 && (n_xfer - n0) < 3; i++) cycles(1);
        resetn = 1'b0;
        cycles(2);
        @(negedge clk);
        check("reset_mid_word_ready", if_l.din_ready, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_mid_word_outputs", {if_l.dout_valid, busy_l, if_m.dout_valid, busy_m, if_l.din_ready}, 5'b00001);
        @(posedge clk);
        #1;
        n0 = n_xfer;
        cycles(10);
        check("reset_no_more_bits", n_xfer - n0, 0);

        // Over-long length is clamped
        n0 = n_xfer;
        send(8'h5A, 4'd12);
        wait_idle();
        check("clamped_bit_count", n_xfer - n0, 8);

        // Randomised traffic with random back-pressure and occasional flushes
        rdy_mode = 3;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 4));
            send(DW'($urandom), LW'($urandom_range(0, 15)));
            if (k % 37 == 36) begin
                flush = 1'b1;
                cycles(1);
                flush = 1'b0;
            end
        end
        rdy_mode = 1;
        wait_idle();
        check("scoreboard_drained", q_l.size() + q_m.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
